multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Parametrised successor to the fixed multicycle control FSM: sequences fetch / decode / execute / memory / writeback for the ARM-subset datapath.
- Adds a variable-latency memory handshake (mem_req/mem_ready) with an optional timeout.
- Adds a multi-cycle multiply state with configurable latency, condition-fail squashing and undefined-op reporting.
- Sits between the decoder and the multicycle datapath; every datapath strobe and mux select comes from here.

Parameters:
- MUL_CYCLES, 3: cycles spent in EXECM (>=1).
- WAIT_TIMEOUT, 16: maximum cycles mem_req may be held without mem_ready; 0 disables the timeout.
- CNT_W, 5: internal counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, WAIT_TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  2  instr[27:26].
- funct  in  6  instr[25:20].
- mul_flag  in  1  decoder multiply indication.
- cond_ex  in  1  condition check passed; sampled in DECODE.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request active.
- mem_w  out  1  write request (only with mem_req).
- adr_src  out  1  0=PC, 1=ALU result.
- ir_write  out  1  latch instruction.
- pc_write  out  1  PC update (fetch increment).
- branch  out  1  branch PC update.
- link  out  1  write return address to r14 (BL).
- reg_w  out  1  register file write.
- alu_src_a  out  1  0=reg, 1=PC.
- alu_src_b  out  2  00=reg, 01=imm, 10=const 4.
- alu_op  out  1  ALU decodes funct.
- result_src  out  2  00=ALUOut, 01=mem data, 10=ALU direct, 11=mul result.
- mul_start  out  1  one-cycle multiplier start.
- bus_err  out  1  one-cycle pulse on memory timeout.
- undef  out  1  one-cycle pulse on op==11.
- state_o  out  4  current state, for debug.

Behaviour:
- Registered state; outputs are a combinational decode of the state plus mem_ready. Counter cnt is CNT_W bits; mul_pending is a 1-bit register.
- Reset: state<=FETCH, cnt<=0, mul_pending<=0. While reset is high, all strobes (mem_req, mem_w, ir_write, pc_write, branch, link, reg_w, mul_start, bus_err, undef) are forced 0 and all selects are 0. Reset mid-wait or mid-multiply abandons the operation with no write.
- State encoding: FETCH=0, DECODE=1, MEMADDR=2, EXECR=3, EXECI=4, EXECM=5, BRANCH=6, MEMREAD=7, MEMWRITE=8, ALUWB=9, MEMWB=10.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10.
  - ir_write and pc_write assert only in the cycle mem_ready=1; next state DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=1, alu_src_b=10. Next state, in priority order:
  - !cond_ex -> FETCH (squash, no writes).
  - op==11 -> undef=1 this cycle, -> FETCH.
  - op==01 -> MEMADDR.
  - op==10 -> BRANCH.
  - op==00 & !funct[5] & mul_flag -> EXECM.
  - op==00 & !funct[5] -> EXECR.
  - op==00 & funct[5] -> EXECI.
- MEMADDR: alu_src_b=01. Next is MEMREAD if funct[0], else MEMWRITE.
- EXECR: alu_op=1, alu_src_b=00, then ALUWB. EXECI: alu_op=1, alu_src_b=01, then ALUWB.
- EXECM:
  - mul_start=1 on the first cycle only (cnt==0); cnt increments each cycle.
  - At cnt==MUL_CYCLES-1: cnt<=0, mul_pending<=1, next ALUWB.
  - MUL_CYCLES=1 gives a single EXECM cycle with mul_start=1.
- ALUWB: reg_w=1, result_src = 11 if mul_pending else 00; mul_pending<=0; next FETCH.
- BRANCH: branch=1, alu_src_b=01, result_src=10; link=1 when funct[4]; next FETCH.
- MEMREAD / MEMWRITE:
  - mem_req=1, adr_src=1; MEMWRITE also drives mem_w=1.
  - On mem_ready: MEMREAD -> MEMWB, MEMWRITE -> FETCH.
- MEMWB: reg_w=1, result_src=01; next FETCH.
- Timeout (all mem_req states, WAIT_TIMEOUT>0):
  - cnt counts wait cycles and clears on state change.
  - If cnt==WAIT_TIMEOUT-1 and !mem_ready: bus_err=1 for that cycle, no ir_write/reg_w/mem completion, cnt<=0, next FETCH.
  - mem_ready in the same cycle as the timeout wins; no error is raised.
- Unknown state value -> FETCH.

Decomposition:
- ctrl_pkg holds the state encodings, the result_src and alu_src_b constants, and the op codes.
- One sub-module, ctrl_cycle_counter: CNT_W counter with clear/enable/terminal-compare. It is shared by the multiply and timeout paths, which are never active together.

Test Plan:
- Reset mid-MEMREAD with mem_req high -> next cycle state_o=0, all strobes 0, no reg_w ever issued for that load.
- Fetch with mem_ready low for 3 cycles, then high -> mem_req held 4 cycles, ir_write/pc_write exactly 1 cycle (the 4th), then DECODE.
- MUL (op=00, funct=000000, mul_flag=1), MUL_CYCLES=3 -> mul_start 1 cycle, 3 EXECM cycles, ALUWB with result_src=11, reg_w=1.
- LDR with mem_ready never asserted, WAIT_TIMEOUT=16 -> bus_err pulses on the 16th MEMREAD cycle, no MEMWB, returns to FETCH; repeat with mem_ready on that same cycle -> no bus_err, MEMWB entered.
- cond_ex=0 on a STR in DECODE -> FETCH next, mem_w never asserted; op=11 -> undef 1 cycle in DECODE.
- BL (op=10, funct=110000) -> BRANCH with branch=1, link=1; B (funct=100000) -> link=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller:
// FSM states, mux selects and instruction op classes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    EXECR    = 4'd3,
    EXECI    = 4'd4,
    EXECM    = 4'd5,
    BRANCH   = 4'd6,
    MEMREAD  = 4'd7,
    MEMWRITE = 4'd8,
    ALUWB    = 4'd9,
    MEMWB    = 4'd10
  } state_t;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_MUL    = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_counter.sv
// Cycle counter shared by the multiply and memory-wait paths;
// the two never run in the same state.
module ctrl_cycle_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign done = (cnt == term);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the ARM-subset datapath with
// variable-latency memory, wait timeout and multi-cycle multiply.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MUL_CYCLES   = 3,
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       mul_flag,
  input  logic       cond_ex,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_w,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       link,
  output logic       reg_w,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_op,
  output logic [1:0] result_src,
  output logic       mul_start,
  output logic       bus_err,
  output logic       undef,
  output logic [3:0] state_o
);

  localparam logic [CNT_W-1:0] MUL_TERM = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TERM  = CNT_W'(WAIT_TIMEOUT - 1);
  localparam bit               TO_EN    = (WAIT_TIMEOUT > 0);

  state_t           state;
  state_t           nxt;
  logic             mul_pending;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             cnt_done;
  logic             cnt_en;
  logic             cnt_clr;
  logic             wait_st;
  logic             timeout;
  logic             unused_funct;

  assign unused_funct = ^funct[3:1];

  ctrl_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (term),
    .cnt   (cnt),
    .done  (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      mul_pending <= 1'b0;
    end else begin
      state <= nxt;
      if (state == EXECM && cnt_done)
        mul_pending <= 1'b1;
      else if (state == ALUWB)
        mul_pending <= 1'b0;
    end
  end

  assign wait_st = (state == FETCH) ||
                   (state == MEMREAD) ||
                   (state == MEMWRITE);
  assign term    = (state == EXECM) ? MUL_TERM : TO_TERM;
  assign timeout = TO_EN && wait_st && cnt_done && !mem_ready;
  assign state_o = state;

  always_comb begin
    nxt        = state;
    mem_req    = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    link       = 1'b0;
    reg_w      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = 1'b0;
    result_src = RES_ALUOUT;
    mul_start  = 1'b0;
    bus_err    = 1'b0;
    undef      = 1'b0;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (!cond_ex)
          nxt = FETCH;
        else if (op == OP_UND) begin
          undef = 1'b1;
          nxt   = FETCH;
        end else if (op == OP_MEM)
          nxt = MEMADDR;
        else if (op == OP_BR)
          nxt = BRANCH;
        else if (!funct[5] && mul_flag)
          nxt = EXECM;
        else if (!funct[5])
          nxt = EXECR;
        else
          nxt = EXECI;
      end
      MEMADDR: begin
        alu_src_b = SRCB_IMM;
        nxt = funct[0] ? MEMREAD : MEMWRITE;
      end
      EXECR: begin
        alu_op = 1'b1;
        nxt    = ALUWB;
      end
      EXECI: begin
        alu_op    = 1'b1;
        alu_src_b = SRCB_IMM;
        nxt       = ALUWB;
      end
      EXECM: begin
        mul_start = (cnt == '0);
        if (cnt_done)
          nxt = ALUWB;
      end
      ALUWB: begin
        reg_w      = 1'b1;
        result_src = mul_pending ? RES_MUL : RES_ALUOUT;
        nxt        = FETCH;
      end
      BRANCH: begin
        branch     = 1'b1;
        link       = funct[4];
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        nxt        = FETCH;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)
          nxt = MEMWB;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        mem_w   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)
          nxt = FETCH;
      end
      MEMWB: begin
        reg_w      = 1'b1;
        result_src = RES_MEM;
        nxt        = FETCH;
      end
      default: nxt = FETCH;
    endcase

    // Timeout overrides the stay-and-wait path; mem_ready already won above
    if (timeout) begin
      bus_err = 1'b1;
      nxt     = FETCH;
    end

    cnt_en  = (state == EXECM) || (wait_st && TO_EN);
    cnt_clr = (nxt != state) || timeout;

    if (reset) begin
      mem_req    = 1'b0;
      mem_w      = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      link       = 1'b0;
      reg_w      = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_op     = 1'b0;
      result_src = RES_ALUOUT;
      mul_start  = 1'b0;
      bus_err    = 1'b0;
      undef      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (MUL_CYCLES=3,
// WAIT_TIMEOUT=16) with hand-computed expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mul_flag;
  logic       cond_ex;
  logic       mem_ready;
  logic       mem_req, mem_w, adr_src, ir_write, pc_write;
  logic       branch, link, reg_w, alu_src_a, alu_op;
  logic       mul_start, bus_err, undef;
  logic [1:0] alu_src_b, result_src;
  logic [3:0] state_o;

  int n_run  = 0;
  int n_fail = 0;
  int berr_n;
  int rw_n;

  multicycle_ctrl #(
    .MUL_CYCLES(3), .WAIT_TIMEOUT(16), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .mul_flag(mul_flag), .cond_ex(cond_ex),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_w(mem_w),
    .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .link(link),
    .reg_w(reg_w), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .mul_start(mul_start),
    .bus_err(bus_err), .undef(undef), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Complete a fetch immediately and present the decode inputs
  task automatic fetch(input logic [1:0] o, input logic [5:0] f,
                       input logic m, input logic c);
    mem_ready = 1'b1;
    op = o; funct = f; mul_flag = m; cond_ex = c;
    #1;
    chk("fetch_st", state_o, 0);
    step();
    mem_ready = 1'b0;
    #1;
    chk("dec_st", state_o, 1);
  endtask

  initial begin
    reset = 1'b1; op = 2'b00; funct = 6'd0;
    mul_flag = 1'b0; cond_ex = 1'b1; mem_ready = 1'b0;
    step(); step();
    chk("rst_memreq", mem_req, 0);
    chk("rst_srcb", alu_src_b, 0);
    reset = 1'b0;
    #1;
    chk("rst_state", state_o, 0);

    // Fetch waits 3 cycles then completes on the 4th
    for (int i = 0; i < 3; i++) begin
      chk("fw_req", mem_req, 1);
      chk("fw_irw", ir_write, 0);
      chk("fw_pcw", pc_write, 0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("fw_req4", mem_req, 1);
    chk("fw_irw4", ir_write, 1);
    chk("fw_pcw4", pc_write, 1);
    chk("fw_srcb", alu_src_b, 2'b10);
    step();
    mem_ready = 1'b0;
    #1;
    chk("fw_dec", state_o, 1);
    chk("fw_irw5", ir_write, 0);

    // MUL: decode was from op=00 funct=0, now with mul_flag
    mul_flag = 1'b1;
    #1;
    step();
    chk("mul_st1", state_o, 5);
    chk("mul_start1", mul_start, 1);
    step();
    chk("mul_st2", state_o, 5);
    chk("mul_start2", mul_start, 0);
    step();
    chk("mul_st3", state_o, 5);
    chk("mul_start3", mul_start, 0);
    step();
    chk("mul_wb", state_o, 9);
    chk("mul_regw", reg_w, 1);
    chk("mul_res", result_src, 2'b11);
    step();
    chk("mul_back", state_o, 0);

    // Plain EXECR: result_src back to ALUOut
    fetch(2'b00, 6'b000000, 1'b0, 1'b1);
    step();
    chk("exr_st", state_o, 3);
    chk("exr_aluop", alu_op, 1);
    step();
    chk("exr_res", result_src, 2'b00);
    step();

    // EXECI
    fetch(2'b00, 6'b100000, 1'b0, 1'b1);
    step();
    chk("exi_st", state_o, 4);
    chk("exi_srcb", alu_src_b, 2'b01);
    step(); step();

    // LDR timeout
    fetch(2'b01, 6'b000001, 1'b0, 1'b1);
    step();
    chk("ldr_addr", state_o, 2);
    chk("ldr_srcb", alu_src_b, 2'b01);
    step();
    berr_n = 0;
    for (int i = 1; i < 16; i++) begin
      if (bus_err) berr_n++;
      if (state_o != 4'd7) berr_n++;
      step();
    end
    chk("to_early", berr_n, 0);
    chk("to_memreq", mem_req, 1);
    chk("to_berr", bus_err, 1);
    chk("to_regw", reg_w, 0);
    step();
    chk("to_back", state_o, 0);
    chk("to_pulse", bus_err, 0);

    // LDR with ready on the timeout cycle
    fetch(2'b01, 6'b000001, 1'b0, 1'b1);
    step(); step();
    for (int i = 1; i < 16; i++) step();
    mem_ready = 1'b1;
    #1;
    chk("rdy_st", state_o, 7);
    chk("rdy_berr", bus_err, 0);
    step();
    mem_ready = 1'b0;
    #1;
    chk("rdy_wb", state_o, 10);
    chk("rdy_regw", reg_w, 1);
    chk("rdy_res", result_src, 2'b01);
    step();

    // STR completes after one wait
    fetch(2'b01, 6'b000000, 1'b0, 1'b1);
    step(); step();
    chk("str_st", state_o, 8);
    chk("str_w", mem_w, 1);
    chk("str_adr", adr_src, 1);
    step();
    mem_ready = 1'b1;
    #1;
    step();
    mem_ready = 1'b0;
    #1;
    chk("str_back", state_o, 0);

    // Squashed STR
    fetch(2'b01, 6'b000000, 1'b0, 1'b0);
    chk("sq_memw", mem_w, 0);
    step();
    chk("sq_back", state_o, 0);
    chk("sq_memw2", mem_w, 0);

    // Undefined op
    fetch(2'b11, 6'b000000, 1'b0, 1'b1);
    chk("und_pulse", undef, 1);
    step();
    chk("und_back", state_o, 0);
    chk("und_clr", undef, 0);

    // BL then B
    fetch(2'b10, 6'b110000, 1'b0, 1'b1);
    step();
    chk("bl_st", state_o, 6);
    chk("bl_br", branch, 1);
    chk("bl_link", link, 1);
    step();
    fetch(2'b10, 6'b100000, 1'b0, 1'b1);
    step();
    chk("b_br", branch, 1);
    chk("b_link", link, 0);
    step();

    // Reset in the middle of a load wait
    fetch(2'b01, 6'b000001, 1'b0, 1'b1);
    step(); step(); step();
    chk("rm_st", state_o, 7);
    chk("rm_req", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("rm_req0", mem_req, 0);
    chk("rm_adr0", adr_src, 0);
    rw_n = 0;
    step();
    chk("rm_state", state_o, 0);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (reg_w) rw_n++;
      step();
    end
    chk("rm_noregw", rw_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
